// File: rtl/tl_uart_tx_pkg.sv
// Shared constants and bus payload types for the TileLink UART transmitter.
// Holds register indices, STATUS bit positions, the serial FSM state enum and TL-UL beats.
package tl_uart_tx_pkg;

  localparam int unsigned TL_ADDR_W = 32;
  localparam int unsigned TL_DATA_W = 32;
  localparam int unsigned TL_MASK_W = TL_DATA_W / 8;
  localparam int unsigned TL_SRC_W  = 4;
  localparam int unsigned TL_SIZE_W = 3;
  localparam int unsigned DIV_W     = 16;

  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  // Register index as seen on a_address[3:2]
  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;

  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_EMPTY     = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

  typedef struct packed {
    logic                 a_valid;
    logic [2:0]           a_opcode;
    logic [2:0]           a_param;
    logic [TL_SIZE_W-1:0] a_size;
    logic [TL_SRC_W-1:0]  a_source;
    logic [TL_ADDR_W-1:0] a_address;
    logic [TL_MASK_W-1:0] a_mask;
    logic [TL_DATA_W-1:0] a_data;
  } tilelink_a;

  typedef struct packed {
    logic                 d_valid;
    logic [2:0]           d_opcode;
    logic [1:0]           d_param;
    logic [TL_SIZE_W-1:0] d_size;
    logic [TL_SRC_W-1:0]  d_source;
    logic                 d_error;
    logic [TL_DATA_W-1:0] d_data;
  } tilelink_d;

endpackage

// File: rtl/tl_uart_tx_sync_fifo.sv
// Synchronous FIFO with show-ahead read data and registered full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module tl_uart_tx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

endmodule

// File: rtl/tl_uart_tx.sv
// TileLink-attached 8N1 UART transmitter: register decode, TX FIFO and bit-serial shifter.
// Responses are registered and appear one cycle after each selected A beat.
module tl_uart_tx
  import tl_uart_tx_pkg::*;
#(
  parameter logic [31:0]   addr_mask  = 32'hF000_0000,
  parameter logic [31:0]   addr_tag   = 32'h4000_0000,
  parameter int unsigned   fifo_depth = 8,
  parameter logic [15:0]   div_reset  = 16'd16
) (
  input  logic      clock,
  input  logic      reset_in_n,
  input  tilelink_a bus_tla,
  output tilelink_d bus_tld,
  output logic      tx,
  output logic      tx_busy
);

  localparam int unsigned CNT_W = $clog2(fifo_depth) + 1;

  logic                 sel, is_get, is_put, txdata_wr, push, pop;
  logic [1:0]           idx;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [7:0]           fifo_rdata, count8;
  logic [TL_DATA_W-1:0] rdata;
  logic [DIV_W-1:0]     div_q, div_d, div_m1;
  logic                 ovf_q, ovf_d;
  tilelink_d            resp_q, resp_d;
  uart_state_e          state_q, state_d;
  logic [2:0]           bit_q, bit_d;
  logic [DIV_W-1:0]     timer_q, timer_d, reload_q, reload_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d, busy_q, busy_d;
  logic                 unused_tla;

  assign unused_tla = ^{bus_tla.a_param, bus_tla.a_mask[3:2], bus_tla.a_data[31:16]};

  tl_uart_tx_sync_fifo #(.WIDTH(8), .DEPTH(fifo_depth)) u_fifo (
    .clk       (clock),
    .rst_n     (reset_in_n),
    .push      (push),
    .push_data (bus_tla.a_data[7:0]),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Bus decode, register writes and D-channel response
  always_comb begin
    sel       = bus_tla.a_valid && ((bus_tla.a_address & addr_mask) == addr_tag);
    idx       = bus_tla.a_address[3:2];
    is_get    = (bus_tla.a_opcode == TL_GET);
    is_put    = (bus_tla.a_opcode == TL_PUT_FULL) || (bus_tla.a_opcode == TL_PUT_PARTIAL);
    txdata_wr = sel && is_put && (idx == UART_TXDATA) && bus_tla.a_mask[0];
    push      = txdata_wr && !fifo_full;
    count8    = (32'(fifo_count) > 32'd255) ? 8'hFF : 8'(fifo_count);

    rdata = '0;
    if (idx == UART_STATUS) begin
      rdata[ST_BUSY]             = busy_q;
      rdata[ST_FULL]             = fifo_full;
      rdata[ST_EMPTY]            = fifo_empty;
      rdata[ST_OVF]              = ovf_q;
      rdata[ST_COUNT_LSB +: 8]   = count8;
    end else if (idx == UART_DIV) begin
      rdata = TL_DATA_W'(div_q);
    end

    div_d = div_q;
    if (sel && is_put && (idx == UART_DIV)) begin
      if (bus_tla.a_mask[0]) div_d[7:0]  = bus_tla.a_data[7:0];
      if (bus_tla.a_mask[1]) div_d[15:8] = bus_tla.a_data[15:8];
    end

    // Overflow set wins over a same-cycle clear from a STATUS read
    ovf_d = ovf_q;
    if (sel && is_get && (idx == UART_STATUS)) ovf_d = 1'b0;
    if (txdata_wr && fifo_full)                ovf_d = 1'b1;

    resp_d = '0;
    if (sel) begin
      resp_d.d_valid  = 1'b1;
      resp_d.d_size   = bus_tla.a_size;
      resp_d.d_source = bus_tla.a_source;
      if (is_get) begin
        resp_d.d_opcode = TL_ACCESS_ACK_DATA;
        resp_d.d_data   = rdata;
      end else begin
        resp_d.d_opcode = TL_ACCESS_ACK;
        resp_d.d_error  = !is_put;
      end
    end
  end

  assign div_m1 = (div_q == '0) ? '0 : div_q - 16'd1;

  // Serial FSM; the divisor is latched into reload at each frame start
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    timer_d  = timer_q;
    reload_d = reload_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    case (state_q)
      UART_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = fifo_rdata;
          timer_d  = div_m1;
          reload_d = div_m1;
          state_d  = UART_START;
        end
      end
      UART_START: begin
        if (timer_q == '0) begin
          timer_d = reload_q;
          bit_d   = 3'd0;
          state_d = UART_DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      UART_DATA: begin
        if (timer_q == '0) begin
          timer_d = reload_q;
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        if (timer_q == '0) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            shift_d  = fifo_rdata;
            timer_d  = div_m1;
            reload_d = div_m1;
            state_d  = UART_START;
          end else begin
            state_d = UART_IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
    endcase

    case (state_d)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = shift_d[0];
      default:    tx_d = 1'b1;
    endcase
    busy_d = (state_d != UART_IDLE) || push || (fifo_count != CNT_W'(pop));
  end

  always_ff @(posedge clock or negedge reset_in_n) begin
    if (!reset_in_n) begin
      div_q    <= div_reset;
      ovf_q    <= 1'b0;
      resp_q   <= '0;
      state_q  <= UART_IDLE;
      bit_q    <= '0;
      timer_q  <= '0;
      reload_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      ovf_q    <= ovf_d;
      resp_q   <= resp_d;
      state_q  <= state_d;
      bit_q    <= bit_d;
      timer_q  <= timer_d;
      reload_q <= reload_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign bus_tld = resp_q;
  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule
